seq_ctrl: RTL
=============

SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter: PC_W, default 4, program counter width; program space is 2^PC_W words.
REQ-002 clk_i  input  1  sole clock, rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 op_i  input  4  opcode field of current instruction.
REQ-005 imm_i, jmp_i, mr_i, mw_i, inp_i, out_i, alu_i  input  1 each  decoded control strobes for op_i.
REQ-006 operand_i  input  PC_W  address/target field of current instruction.
REQ-007 carry_i, zero_i  input  1 each  ALU flags.
REQ-008 mem_ack_i  input  1  memory completes the current request this cycle.
REQ-009 in_valid_i  input  1  input port data present.
REQ-010 in_ready_o  output  1  sequencer accepts input port data.
REQ-011 out_valid_o  output  1  accumulator presented on output port.
REQ-012 out_ready_i  input  1  output port consumes data.
REQ-013 pc_o  output  PC_W  program counter.
REQ-014 mem_req_o, mem_we_o  output  1 each  memory request, write enable.
REQ-015 addr_sel_o  output  1  memory address source: 0 = pc_o, 1 = operand_i.
REQ-016 ir_load_o, acc_load_o, flags_load_o  output  1 each  single-cycle load strobes.
REQ-017 acc_src_o  output  2  accumulator source: 0 memory, 1 immediate, 2 ALU, 3 input port.
REQ-018 state_o  output  3  state: FETCH=0, DECODE=1, MEM=2, IO=3, EXEC=4, HALT=5.

Function
REQ-019 All outputs except pc_o and state_o SHALL be combinational decodes of state and inputs; pc_o and state register updates on clk_i rising edge.
REQ-020 FETCH: mem_req_o=1, mem_we_o=0, addr_sel_o=0; hold until mem_ack_i; ack cycle asserts ir_load_o and moves to DECODE.
REQ-021 DECODE (one cycle, no strobes): mr_i|mw_i -> MEM; inp_i|out_i -> IO; otherwise -> EXEC.
REQ-022 MEM: mem_req_o=1, addr_sel_o=1, mem_we_o=mw_i; on mem_ack_i: mr_i&!alu_i -> acc_load_o=1, acc_src_o=0; mr_i&alu_i -> acc_load_o=1, flags_load_o=1, acc_src_o=2; mw_i -> no load; instruction completes.
REQ-023 IO input: in_ready_o=1; completes on in_valid_i with acc_load_o=1, acc_src_o=3.
REQ-024 IO output: out_valid_o=1; completes on out_ready_i; no load.
REQ-025 EXEC (one cycle): imm_i -> acc_load_o=1, acc_src_o=1; alu_i -> acc_load_o=1, flags_load_o=1, acc_src_o=2; jmp_i -> branch evaluated; completes.
REQ-026 Branch taken: op_i=0111 always; op_i=0101 if carry_i; op_i=0110 if zero_i; flags sampled in EXEC cycle only.
REQ-027 Completion cycle: taken branch loads pc_o<=operand_i, else pc_o<=pc_o+1 modulo 2^PC_W (2^PC_W-1 wraps to 0); next state FETCH.
REQ-028 Minimum latency: 3 cycles per instruction (FETCH ack first cycle, DECODE, one MEM/IO/EXEC cycle); each wait cycle adds one.
REQ-029 mem_ack_i outside FETCH/MEM, in_valid_i and out_ready_i outside IO SHALL be ignored.
REQ-030 Branch to own address SHALL be legal (tight loop); no strobe asserted in DECODE SHALL execute as NOP via EXEC.

Reset
REQ-031 rst_ni low SHALL immediately force pc_o=0, state FETCH, all load/request/handshake outputs 0, abandoning any in-flight request.
REQ-032 First fetch (address 0) SHALL be requested in the first cycle after rst_ni deasserts.

Configuration
REQ-033 SEQ_CTRL_SINGLE_STEP_EN defined: adds input step_i (1); completion goes to HALT instead of FETCH; HALT asserts nothing and exits to FETCH on step_i=1.
REQ-034 SEQ_CTRL_SINGLE_STEP_EN undefined: no step_i port, completion goes directly to FETCH, state 5 unreachable.

Verification
REQ-035 Reset release, mem_ack_i tied 1, LDI at address 0 -> states 0,1,4, acc_load_o with acc_src_o=1 in cycle 3, pc_o=1.
REQ-036 ADD with mem_ack_i delayed 2 cycles in MEM -> MEM held 3 cycles, acc_load_o and flags_load_o together on ack, acc_src_o=2.
REQ-037 BRZ operand 9 with zero_i=1 -> pc_o=9; zero_i=0 -> pc_o=pc+1; JMP at pc 15 (PC_W=4) to 15 -> loops; non-branch at 15 -> pc_o=0.
REQ-038 INP with in_valid_i low 4 cycles -> in_ready_o high throughout, single acc_load_o with acc_src_o=3 on valid; OUT similar with out_ready_i.
REQ-039 rst_ni pulsed low mid MEM wait -> mem_req_o drops asynchronously, pc_o=0, FETCH after release.
REQ-040 With SEQ_CTRL_SINGLE_STEP_EN: state_o=5 after each instruction, pc_o frozen until step_i pulse.

Source files
------------

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/MEM|IO|EXEC instruction sequencer.
// Define SEQ_CTRL_SINGLE_STEP_EN to park in HALT after each instruction until step_i.
module seq_ctrl #(
  parameter int PC_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
`ifdef SEQ_CTRL_SINGLE_STEP_EN
  input  logic            step_i,
`endif
  input  logic [3:0]      op_i,
  input  logic            imm_i,
  input  logic            jmp_i,
  input  logic            mr_i,
  input  logic            mw_i,
  input  logic            inp_i,
  input  logic            out_i,
  input  logic            alu_i,
  input  logic [PC_W-1:0] operand_i,
  input  logic            carry_i,
  input  logic            zero_i,
  input  logic            mem_ack_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            addr_sel_o,
  output logic            ir_load_o,
  output logic            acc_load_o,
  output logic            flags_load_o,
  output logic [1:0]      acc_src_o,
  output logic [2:0]      state_o
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] MEM    = 3'd2;
  localparam logic [2:0] IO     = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;
  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            done, taken;
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = 1'b0;
    ir_load_o    = 1'b0;
    acc_load_o   = 1'b0;
    flags_load_o = 1'b0;
    acc_src_o    = 2'd0;
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    done         = 1'b0;
    taken        = 1'b0;
    state_d      = state_q;
    case (state_q)
      FETCH: begin
        mem_req_o = 1'b1;
        ir_load_o = mem_ack_i;
        state_d   = mem_ack_i ? DECODE : FETCH;
      end
      DECODE: state_d = (mr_i | mw_i) ? MEM : (inp_i | out_i) ? IO : EXEC;
      MEM: begin
        mem_req_o    = 1'b1;
        addr_sel_o   = 1'b1;
        mem_we_o     = mw_i;
        done         = mem_ack_i;
        acc_load_o   = mem_ack_i & mr_i;
        flags_load_o = mem_ack_i & mr_i & alu_i;
        acc_src_o    = (mr_i & alu_i) ? 2'd2 : 2'd0;
      end
      IO: begin
        in_ready_o  = inp_i;
        out_valid_o = !inp_i;
        done        = inp_i ? in_valid_i : out_ready_i;
        acc_load_o  = inp_i & in_valid_i;
        acc_src_o   = 2'd3;
      end
      EXEC: begin
        done         = 1'b1;
        acc_load_o   = imm_i | alu_i;
        flags_load_o = alu_i;
        acc_src_o    = imm_i ? 2'd1 : alu_i ? 2'd2 : 2'd0;
        taken        = jmp_i & ((op_i == 4'b0111) | ((op_i == 4'b0101) & carry_i) |
                                ((op_i == 4'b0110) & zero_i));
      end
`ifdef SEQ_CTRL_SINGLE_STEP_EN
      HALT:    state_d = step_i ? FETCH : HALT;
`else
      HALT:    state_d = FETCH;
`endif
      default: state_d = FETCH;
    endcase
    pc_d = done ? (taken ? operand_i : pc_q + PC_W'(1)) : pc_q;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
    if (done) state_d = HALT;
`else
    if (done) state_d = FETCH;
`endif
    // Reset holds state at FETCH, so its request must be masked while rst_ni is low.
    if (!rst_ni) begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      ir_load_o    = 1'b0;
      acc_load_o   = 1'b0;
      flags_load_o = 1'b0;
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign pc_o    = pc_q;
  assign state_o = state_q;
endmodule
